// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared definitions for the GPIO interrupt controller:
// bus widths, register offsets, edge codes and register decode.
package gpio_irq_ctrl_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_BUS      = 32;

    localparam logic [7:0] GPIO_IRQ_EN    = 8'h00;
    localparam logic [7:0] GPIO_IRQ_EDGE  = 8'h04;
    localparam logic [7:0] GPIO_IRQ_PEND  = 8'h08;
    localparam logic [7:0] GPIO_IRQ_MASK  = 8'h0C;
    localparam logic [7:0] GPIO_IRQ_DBLIM = 8'h10;
    localparam logic [7:0] GPIO_IRQ_LEVEL = 8'h14;

    localparam int TIMER0_INT_BIT = 0;
    localparam int GPIO_INT_BIT   = 1;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_e;

    typedef enum logic [2:0] {
        REG_EN,
        REG_EDGE,
        REG_PEND,
        REG_MASK,
        REG_DBLIM,
        REG_LEVEL,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(input logic [7:0] off);
        reg_sel_e sel;
        case (off)
            GPIO_IRQ_EN:    sel = REG_EN;
            GPIO_IRQ_EDGE:  sel = REG_EDGE;
            GPIO_IRQ_PEND:  sel = REG_PEND;
            GPIO_IRQ_MASK:  sel = REG_MASK;
            GPIO_IRQ_DBLIM: sel = REG_DBLIM;
            GPIO_IRQ_LEVEL: sel = REG_LEVEL;
            default:        sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic edge_has_rise(input edge_e code);
        return (code == EDGE_RISE) || (code == EDGE_BOTH);
    endfunction

    function automatic logic edge_has_fall(input edge_e code);
        return (code == EDGE_FALL) || (code == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/gpio_irq_pin.sv
// One monitored pin: synchroniser chain, debounce counter and
// stable level with single-cycle rise/fall strobes on update.
module gpio_irq_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pin_i,
    input  logic [DB_WIDTH-1:0] lim_i,
    output logic                stable_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic                   stable_d;
    logic [DB_WIDTH-1:0]    cnt_q;
    logic [DB_WIDTH-1:0]    cnt_d;
    logic [DB_WIDTH-1:0]    last;
    logic                   sync_bit;
    logic                   update;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // A limit of zero behaves as one; >= lets a lowered limit fire at once.
    assign last   = (lim_i == '0) ? '0 : lim_i - DB_WIDTH'(1);
    assign update = (sync_bit != stable_q) && (cnt_q >= last);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_bit == stable_q) begin
            cnt_d = '0;
        end else if (update) begin
            stable_d = sync_bit;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DB_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = update & sync_bit;
    assign fall_o   = update & ~sync_bit;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// RIB slave turning debounced GPIO edges into a level interrupt
// (core interrupt bit 1); holds registers, decode and PEND.
module gpio_irq_ctrl
    import gpio_irq_ctrl_pkg::*;
#(
    parameter int NUM_IO      = 16,
    parameter int DB_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [MEM_ADDR_BUS-1:0] addr_i,
    input  logic [MEM_BUS-1:0]      data_i,
    output logic [MEM_BUS-1:0]      data_o,
    input  logic [NUM_IO-1:0]       io_pin_i,
    output logic                    int_o
);

    logic [NUM_IO-1:0]   en_q;
    logic [NUM_IO-1:0]   en_d;
    logic [2*NUM_IO-1:0] edge_q;
    logic [2*NUM_IO-1:0] edge_d;
    logic [NUM_IO-1:0]   pend_q;
    logic [NUM_IO-1:0]   pend_d;
    logic [NUM_IO-1:0]   mask_q;
    logic [NUM_IO-1:0]   mask_d;
    logic [DB_WIDTH-1:0] dblim_q;
    logic [DB_WIDTH-1:0] dblim_d;

    logic [NUM_IO-1:0]   level;
    logic [NUM_IO-1:0]   rise;
    logic [NUM_IO-1:0]   fall;
    logic [NUM_IO-1:0]   set;
    logic [NUM_IO-1:0]   clr;
    reg_sel_e            sel;
    logic                unused_addr;

    assign sel         = reg_decode(addr_i[7:0]);
    assign unused_addr = ^addr_i[MEM_ADDR_BUS-1:8];

    for (genvar k = 0; k < NUM_IO; k++) begin : g_pin
        gpio_irq_pin #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_WIDTH   (DB_WIDTH)
        ) u_pin (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (io_pin_i[k]),
            .lim_i   (dblim_q),
            .stable_o(level[k]),
            .rise_o  (rise[k]),
            .fall_o  (fall[k])
        );
    end

    always_comb begin
        set = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            edge_e code;
            code   = edge_e'(edge_q[2*k +: 2]);
            set[k] = en_q[k] & ((rise[k] & edge_has_rise(code)) |
                                (fall[k] & edge_has_fall(code)));
        end
    end

    always_comb begin
        en_d    = en_q;
        edge_d  = edge_q;
        mask_d  = mask_q;
        dblim_d = dblim_q;
        clr     = '0;
        if (we_i) begin
            case (sel)
                REG_EN:    en_d    = data_i[NUM_IO-1:0];
                REG_EDGE:  edge_d  = data_i[2*NUM_IO-1:0];
                REG_PEND:  clr     = data_i[NUM_IO-1:0];
                REG_MASK:  mask_d  = data_i[NUM_IO-1:0];
                REG_DBLIM: dblim_d = data_i[DB_WIDTH-1:0];
                default:   ;
            endcase
        end
        // A new event on the same edge as a W1C keeps the bit set.
        pend_d = (pend_q & ~clr) | set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            dblim_q <= '0;
        end else begin
            en_q    <= en_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            dblim_q <= dblim_d;
        end
    end

    always_comb begin
        data_o = '0;
        case (sel)
            REG_EN:    data_o[NUM_IO-1:0]   = en_q;
            REG_EDGE:  data_o[2*NUM_IO-1:0] = edge_q;
            REG_PEND:  data_o[NUM_IO-1:0]   = pend_q;
            REG_MASK:  data_o[NUM_IO-1:0]   = mask_q;
            REG_DBLIM: data_o[DB_WIDTH-1:0] = dblim_q;
            REG_LEVEL: data_o[NUM_IO-1:0]   = level;
            default:   ;
        endcase
    end

    assign int_o = |(pend_q & mask_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: register table, directed corner
// sequences and random pin traffic against a history-based model.
module tb_gpio_irq_ctrl;

    localparam logic [31:0] A_EN    = 32'h00;
    localparam logic [31:0] A_EDGE  = 32'h04;
    localparam logic [31:0] A_PEND  = 32'h08;
    localparam logic [31:0] A_MASK  = 32'h0C;
    localparam logic [31:0] A_DBLIM = 32'h10;
    localparam logic [31:0] A_LEVEL = 32'h14;
    localparam int          SYNC    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [15:0] pins = '0;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_o  (rdata),
        .io_pin_i(pins),
        .int_o   (irq)
    );

    typedef struct {
        bit          do_wr;
        logic [31:0] waddr;
        logic [31:0] wval;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[16];

    // Reference model: pin sample history per edge, all pins packed.
    logic [15:0] raw_h[$];
    logic [15:0] sync_h[$];
    logic [15:0] m_stable;
    logic [15:0] m_pend;
    logic [15:0] m_en;
    logic [15:0] m_mask;
    logic [31:0] m_edg;
    int          m_L;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic model_init();
        raw_h.delete();
        sync_h.delete();
        m_stable = '0;
        m_pend = '0;
    endtask

    // Stable flips once the last L synchronised samples all disagree.
    task automatic model_edge(input logic [15:0] p, input logic [15:0] clr);
        logic [15:0] set;
        set = '0;
        for (int k = 0; k < 16; k++) begin
            bit upd;
            upd = (sync_h.size() >= m_L);
            for (int j = 0; j < m_L && upd; j++)
                if (sync_h[sync_h.size() - 1 - j][k] == m_stable[k]) upd = 0;
            if (upd) begin
                m_stable[k] = ~m_stable[k];
                if (m_en[k] && m_stable[k] && m_edg[2*k]) set[k] = 1'b1;
                if (m_en[k] && !m_stable[k] && m_edg[2*k+1]) set[k] = 1'b1;
            end
        end
        raw_h.push_back(p);
        if (raw_h.size() >= SYNC) sync_h.push_back(raw_h[raw_h.size() - SYNC]);
        else sync_h.push_back('0);
        while (raw_h.size() > 16) void'(raw_h.pop_front());
        while (sync_h.size() > 16) void'(sync_h.pop_front());
        m_pend = (m_pend & ~clr) | set;
    endtask

    task automatic random_round(input int cycles);
        logic [31:0] dbl;
        pins = '0;
        do_reset();
        dbl    = $urandom_range(0, 4);
        m_en   = 16'($urandom);
        m_edg  = $urandom;
        m_mask = 16'($urandom);
        m_L    = (dbl == 0) ? 1 : int'(dbl);
        wr(A_DBLIM, dbl);
        wr(A_EN, {16'h0, m_en});
        wr(A_EDGE, m_edg);
        wr(A_MASK, {16'h0, m_mask});
        model_init();
        for (int c = 0; c < cycles; c++) begin
            logic [15:0] tog;
            logic [15:0] clr;
            tog = '0;
            for (int k = 0; k < 16; k++)
                tog[k] = ($urandom_range(0, 5) == 0);
            pins = pins ^ tog;
            clr = '0;
            if ($urandom_range(0, 7) == 0) begin
                we = 1'b1;
                addr = A_PEND;
                wdata = $urandom;
                clr = wdata[15:0];
            end
            model_edge(pins, clr);
            tick();
            we = 1'b0;
            rd_chk("rnd_pend", A_PEND, {16'h0, m_pend});
            rd_chk("rnd_level", A_LEVEL, {16'h0, m_stable});
            check("rnd_int", {31'h0, irq}, {31'h0, |(m_pend & m_mask)});
        end
    endtask

    initial begin
        bit seen;

        tbl[0]  = '{1'b0, 32'h0,   32'h0,        A_EN,     32'h0,        "rst_en"};
        tbl[1]  = '{1'b0, 32'h0,   32'h0,        A_EDGE,   32'h0,        "rst_edge"};
        tbl[2]  = '{1'b0, 32'h0,   32'h0,        A_PEND,   32'h0,        "rst_pend"};
        tbl[3]  = '{1'b0, 32'h0,   32'h0,        A_MASK,   32'h0,        "rst_mask"};
        tbl[4]  = '{1'b0, 32'h0,   32'h0,        A_DBLIM,  32'h0,        "rst_dblim"};
        tbl[5]  = '{1'b0, 32'h0,   32'h0,        A_LEVEL,  32'h0,        "rst_level"};
        tbl[6]  = '{1'b1, A_EN,    32'hFFFFFFFF, A_EN,     32'h0000FFFF, "en_rw"};
        tbl[7]  = '{1'b1, A_EDGE,  32'hA5A5C3C3, A_EDGE,   32'hA5A5C3C3, "edge_rw"};
        tbl[8]  = '{1'b1, A_MASK,  32'h12345678, A_MASK,   32'h00005678, "mask_rw"};
        tbl[9]  = '{1'b1, A_DBLIM, 32'hFFFF0009, A_DBLIM,  32'h00000009, "dblim_rw"};
        tbl[10] = '{1'b1, A_PEND,  32'hFFFFFFFF, A_PEND,   32'h0,        "pend_w1c"};
        tbl[11] = '{1'b1, A_LEVEL, 32'hFFFFFFFF, A_LEVEL,  32'h0,        "level_ro"};
        tbl[12] = '{1'b1, 32'h18,  32'hFFFFFFFF, 32'h18,   32'h0,        "unmapped_rd"};
        tbl[13] = '{1'b1, 32'h01,  32'h0,        A_EN,     32'h0000FFFF, "odd_addr_wr"};
        tbl[14] = '{1'b0, 32'h0,   32'h0,        32'h10C,  32'h00005678, "upper_addr_rd"};
        tbl[15] = '{1'b1, 32'h200, 32'h00001234, A_EN,     32'h00001234, "alias_wr"};

        do_reset();
        check("rst_int", {31'h0, irq}, 32'h0);
        foreach (tbl[i]) begin
            if (tbl[i].do_wr) wr(tbl[i].waddr, tbl[i].wval);
            rd_chk(tbl[i].name, tbl[i].raddr, tbl[i].exp);
        end

        // Basic rising edge, DBLIM=3: update on edge 5.
        pins = '0;
        do_reset();
        wr(A_DBLIM, 3);
        wr(A_EN, 32'h1);
        wr(A_EDGE, 32'h1);
        wr(A_MASK, 32'h1);
        pins[0] = 1'b1;
        ticks(4);
        rd_chk("basic_edge4_pend", A_PEND, 32'h0);
        check("basic_edge4_int", {31'h0, irq}, 32'h0);
        tick();
        rd_chk("basic_edge5_pend", A_PEND, 32'h1);
        check("basic_edge5_int", {31'h0, irq}, 32'h1);
        rd_chk("basic_level", A_LEVEL, 32'h1);

        // Glitch of 3 cycles against DBLIM=4, then a long pulse.
        pins = '0;
        do_reset();
        wr(A_DBLIM, 4);
        wr(A_EN, 32'h8);
        wr(A_EDGE, 32'h40);
        wr(A_MASK, 32'h8);
        seen = 0;
        pins[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); seen |= irq; end
        pins[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); seen |= irq; end
        rd_chk("glitch_pend", A_PEND, 32'h0);
        rd_chk("glitch_level", A_LEVEL, 32'h0);
        check("glitch_int", {31'h0, seen}, 32'h0);
        pins[3] = 1'b1;
        ticks(5);
        rd_chk("long_edge5_pend", A_PEND, 32'h0);
        tick();
        rd_chk("long_edge6_pend", A_PEND, 32'h8);

        // Both edges on pin 7, masking, W1C and set/clear collision.
        pins = '0;
        do_reset();
        wr(A_DBLIM, 1);
        wr(A_EN, 32'h80);
        wr(A_EDGE, 32'hC000);
        pins[7] = 1'b1;
        ticks(6);
        rd_chk("both_rise", A_PEND, 32'h80);
        check("mask_off_int", {31'h0, irq}, 32'h0);
        wr(A_MASK, 32'h80);
        check("mask_on_int", {31'h0, irq}, 32'h1);
        wr(A_PEND, 32'h80);
        rd_chk("w1c_clear", A_PEND, 32'h0);
        check("w1c_int", {31'h0, irq}, 32'h0);
        pins[7] = 1'b0;
        ticks(6);
        rd_chk("both_fall", A_PEND, 32'h80);
        pins[7] = 1'b1;
        ticks(2);
        wr(A_PEND, 32'h80);
        rd_chk("collision_set_wins", A_PEND, 32'h80);
        wr(A_EN, 32'h0);
        wr(A_EDGE, 32'h0);
        rd_chk("en_clear_keeps", A_PEND, 32'h80);
        check("en_clear_int", {31'h0, irq}, 32'h1);

        // DBLIM=0 behaves as one; disabled pin still tracks LEVEL.
        pins = '0;
        do_reset();
        wr(A_EN, 32'h2);
        wr(A_EDGE, 32'h4);
        pins[1] = 1'b1;
        ticks(2);
        rd_chk("db0_edge2", A_PEND, 32'h0);
        tick();
        rd_chk("db0_edge3", A_PEND, 32'h2);
        wr(A_EDGE, 32'hFFFFFFFF);
        pins[5] = 1'b1;
        ticks(4);
        rd_chk("dis_level_hi", A_LEVEL, 32'h22);
        rd_chk("dis_pend_hi", A_PEND, 32'h2);
        pins[5] = 1'b0;
        ticks(4);
        rd_chk("dis_level_lo", A_LEVEL, 32'h2);
        rd_chk("dis_pend_lo", A_PEND, 32'h2);

        // Asynchronous reset mid-count, then power-up edge.
        pins = '0;
        do_reset();
        wr(A_DBLIM, 1);
        wr(A_EN, 32'hFFFF);
        wr(A_EDGE, 32'hFFFFFFFF);
        wr(A_MASK, 32'hFFFF);
        pins = 16'hFFFF;
        ticks(6);
        rd_chk("all_pend", A_PEND, 32'hFFFF);
        check("all_int", {31'h0, irq}, 32'h1);
        wr(A_DBLIM, 8);
        pins = '0;
        ticks(4);
        rst = 1'b1;
        #1;
        check("async_int", {31'h0, irq}, 32'h0);
        rd_chk("async_en", A_EN, 32'h0);
        rd_chk("async_edge", A_EDGE, 32'h0);
        rd_chk("async_pend", A_PEND, 32'h0);
        rd_chk("async_mask", A_MASK, 32'h0);
        rd_chk("async_dblim", A_DBLIM, 32'h0);
        rd_chk("async_level", A_LEVEL, 32'h0);
        pins = 16'h0004;
        tick();
        @(negedge clk);
        rst = 1'b0;
        wr(A_EN, 32'h4);
        wr(A_EDGE, 32'h10);
        tick();
        rd_chk("powerup_pend", A_PEND, 32'h4);
        rd_chk("powerup_level", A_LEVEL, 32'h4);
        check("powerup_int", {31'h0, irq}, 32'h0);

        for (int r = 0; r < 3; r++) random_round(150);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- RIB slave peripheral that turns GPIO pad inputs into core interrupts.
- Synchronises and debounces each `io_in` bit, then detects rising/falling edges per pin and latches them into pending bits.
- Pending bits are masked and ORed into a single level interrupt, `int_o`. `int_o` drives core interrupt bit 1; timer0 keeps bit 0.
- Occupies one RIB slave slot, uses the plain we/addr/data slave protocol (no req/ack), and sits directly downstream of the GPIO pad logic.

Parameters:
- NUM_IO, 16, number of monitored pins (max 16; register fields are sized for 16).
- DB_WIDTH, 16, width of the debounce limit and of each per-pin counter.
- SYNC_STAGES, 2, flops in each input synchroniser (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- we_i  in  1  register write strobe from RIB.
- addr_i  in  32  byte address; only addr_i[7:0] is decoded.
- data_i  in  32  write data.
- data_o  out  32  read data; combinational from addr_i.
- io_pin_i  in  NUM_IO  raw pad inputs, asynchronous to clk.
- int_o  out  1  level interrupt; high while any masked pending bit is set.

Behaviour:
- Registers (offset, access, reset value):
  - 0x00 EN, RW, 0: per-pin enable in bits [NUM_IO-1:0].
  - 0x04 EDGE, RW, 0: 2 bits per pin (pin k at [2k+1:2k]); 00 none, 01 rising, 10 falling, 11 both.
  - 0x08 PEND, RW1C, 0: writing 1 clears the bit; writing 0 has no effect.
  - 0x0C MASK, RW, 0: 1 = pin contributes to int_o.
  - 0x10 DBLIM, RW, 0: debounce limit N in [DB_WIDTH-1:0].
  - 0x14 LEVEL, RO: debounced stable pin levels.
- Decode:
  - Unmapped offsets read 0; writes to them are ignored.
  - Unused upper bits read 0.
  - Writes take effect at the clock edge when we_i=1.
- Synchroniser: SYNC_STAGES-flop chain per pin producing sync_q. Reset value 0.
- Debounce, per pin, with effective limit L = max(N,1):
  - If sync_q == stable: counter <= 0.
  - Else if counter == L-1: stable <= sync_q and counter <= 0 (the "update").
  - Else: counter++.
  - The debounce runs regardless of EN. Reset: stable=0, counter=0.
- Latency: a pin change that stays constant reaches sync_q after SYNC_STAGES edges. stable and PEND update on the L-th edge after that, i.e. edge SYNC_STAGES+L counted from the first sampling edge.
- Glitch rejection: a level held fewer than L cycles at sync_q never updates stable and never sets PEND.
- Changing DBLIM mid-count: the new L applies immediately. If counter is already ≥ L-1, the update fires on the next mismatch edge.
- Edge detection happens on an update edge only:
  - A rise (stable 0→1) sets PEND[k] if EN[k] and EDGE[k][0].
  - A fall (stable 1→0) sets PEND[k] if EN[k] and EDGE[k][1].
- PEND rules:
  - Set/clear collision on the same edge: set wins, so the bit stays 1.
  - Clearing EN or EDGE does not clear already-pending bits.
- int_o = |(PEND & MASK). It is combinational from registers, so it goes high the same edge PEND sets. Reset value 0.
- Reset mid-operation: all state (sync, stable, counters, registers) returns to reset values asynchronously. int_o drops to 0 without waiting for a clock.
- Power-up: a pin already high at reset produces a rising-edge event once synchronised and debounced, if that edge is enabled.

Decomposition:
- Shared defines: register offsets (GPIO_IRQ_EN … GPIO_IRQ_LEVEL), edge codes (EDGE_NONE/RISE/FALL/BOTH), and the interrupt bit index.
- Bus widths reuse the existing MemAddrBus/MemBus defines.
- One sub-module, gpio_irq_pin: synchroniser, debounce counter, and stable/rise/fall outputs for one pin. It is instantiated NUM_IO times via generate.
- Registers, decode, PEND and int_o stay in the top.

Test Plan:
- Basic rising edge: DBLIM=3, EN=0x0001, EDGE=0x1, MASK=0x1, then pin0 0→1 held → PEND=0x0001 and int_o=1 exactly 5 edges after the first sampling edge; LEVEL=0x0001.
- Glitch rejection: DBLIM=4, pin3 pulse high for 3 cycles → PEND stays 0, LEVEL[3] stays 0, int_o stays 0.
- Both edges and W1C: pin7 EDGE=11, pin rises → PEND=0x0080; write PEND=0x0080 → PEND=0; pin falls → PEND=0x0080 again.
- Masking and collision: PEND bit set with MASK=0 → int_o=0; set MASK=0x0080 → int_o=1. A W1C write on the same edge as a new event → bit remains 1.
- DBLIM=0 and disabled pin: with DBLIM=0, pin change → update after SYNC_STAGES+1 edges. With EN=0, pin toggling → LEVEL tracks the pin and PEND=0.
- Async reset: assert rst mid-count with PEND=0xFFFF → int_o=0, all registers read 0 before the next clock edge; after release, an already-high pin raises a new event once enabled.
